rotate_right_addr_gen_5b: RTL and testbench

ROTATE_RIGHT_ADDR_GEN_5B -- requirements
Module: rotate_right_addr_gen_5b

---
 rtl/rotate_right_addr_gen_5b.sv | 128 ++++++++++++
 tb/tb_rotate_right_addr_gen_5b.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_right_addr_gen_5b.sv
// rotate_right_addr_gen_5b
//
// Generates one 32-point frame of 5-bit addresses. Each issued address is the
// linear index rotated right by a stage-dependent amount k, so a consumer that
// rotates left by the same k recovers the linear index.
//
// Ports
//   clk       in   sole clock, rising edge
//   clr       in   synchronous active-high reset
//   start     in   frame request, sampled only while idle
//   S[2:0]    in   stage select, captured when start is accepted
//   en        in   consumer enable, one address per clock with en=1 while running
//   addr_out  out  registered rotated address
//   idx_out   out  registered linear index matching addr_out
//   valid     out  one-cycle strobe per issued address
//   busy      out  high while a frame is running or finishing
//   done      out  one-cycle pulse after the last address of a frame
//
// Handshake: en acts as the consumer's ready. At every rising edge in RUN with
// en=1 exactly one address is issued; the registered outputs then show it for
// one cycle with valid=1. With en=0 the outputs hold their last value, valid
// drops and the frame stalls. There is no back-pressure path beyond en.

module rotate_right_addr_gen_5b (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic [2:0] S,
    input  logic       en,
    output logic [4:0] addr_out,
    output logic [4:0] idx_out,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [4:0] cnt_q,   cnt_d;
    logic [2:0] s_q,     s_d;
    logic [4:0] addr_q,  addr_d;
    logic [4:0] idx_q,   idx_d;
    logic       valid_q, valid_d;
    logic       done_q,  done_d;

    // Circular right rotation over 5 bits. Stage codes 011..111 all map to
    // k=4, which is the same as a left rotation by 1.
    function automatic logic [4:0] rotr5(input logic [4:0] x, input logic [2:0] stage);
        logic [4:0] r;
        case (stage)
            3'b000:  r = {x[0],   x[4:1]};
            3'b001:  r = {x[1:0], x[4:2]};
            3'b010:  r = {x[2:0], x[4:3]};
            default: r = {x[3:0], x[4]};
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    s_d     = S;
                    cnt_d   = 5'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    addr_d  = rotr5(cnt_q, s_q);
                    idx_d   = cnt_q;
                    valid_d = 1'b1;
                    // cnt wraps 31 -> 0 naturally, leaving it ready for the next frame
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            s_q     <= 3'd0;
            addr_q  <= 5'd0;
            idx_q   <= 5'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign addr_out = addr_q;
    assign idx_out  = idx_q;
    assign valid    = valid_q;
    assign done     = done_q;
    // busy falls in the same cycle done pulses, so a start held through the
    // done cycle is taken on the following edge.
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_rotate_right_addr_gen_5b.sv
module tb_rotate_right_addr_gen_5b;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, start, en;
  logic [2:0] S;
  logic [4:0] addr_out, idx_out;
  logic       valid, busy, done;

  rotate_right_addr_gen_5b dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .S        (S),
    .en       (en),
    .addr_out (addr_out),
    .idx_out  (idx_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int         m_state;
  logic [4:0] m_cnt, m_addr, m_idx;
  logic [2:0] m_s;
  logic       m_valid, m_done;

  function automatic int kf(input logic [2:0] s);
    if (s == 3'd0) return 1;
    if (s == 3'd1) return 2;
    if (s == 3'd2) return 3;
    return 4;
  endfunction

  function automatic logic [4:0] rotl5(input logic [4:0] y, input int k);
    logic [9:0] t;
    t = {5'b0, y} << k;
    return t[4:0] | t[9:5];
  endfunction

  // Expected address found as the value whose left rotation gives the index.
  function automatic logic [4:0] exp_addr(input logic [4:0] cnt, input logic [2:0] s);
    for (int y = 0; y < 32; y++) begin
      if (rotl5(5'(y), kf(s)) == cnt) return 5'(y);
    end
    return 5'd0;
  endfunction

  task automatic model_edge();
    if (clr) begin
      m_state = M_IDLE; m_cnt = 0; m_s = 0; m_addr = 0; m_idx = 0;
      m_valid = 0; m_done = 0;
    end else begin
      m_valid = 0;
      m_done  = 0;
      case (m_state)
        M_IDLE: if (start) begin
          m_s = S; m_cnt = 0; m_state = M_RUN;
        end
        M_RUN: if (en) begin
          m_addr  = exp_addr(m_cnt, m_s);
          m_idx   = m_cnt;
          m_valid = 1;
          if (m_cnt == 5'd31) m_state = M_DONE;
          m_cnt = m_cnt + 5'd1;
        end
        default: begin
          m_done  = 1;
          m_state = M_IDLE;
        end
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- frame bookkeeping ----------------
  int         edge_no, n_valid, done_edge, last_valid_edge, first_idx;
  logic [2:0] frame_s;
  logic       capture_on = 1'b0;
  logic [4:0] cap [8][32];

  task automatic begin_frame();
    edge_no = -1; n_valid = 0; done_edge = -1; last_valid_edge = -1; first_idx = -1;
  endtask

  // ---------------- driver ----------------
  // Drive inputs (called at a falling edge), advance one rising edge, then
  // compare every output with the model on the next falling edge.
  task automatic step(input logic c, input logic st, input logic [2:0] s, input logic e);
    logic [15:0] got, exp;
    clr = c; start = st; S = s; en = e;
    @(posedge clk);
    model_edge();
    edge_no++;
    @(negedge clk);
    got = {3'b0, valid, done, busy, idx_out, addr_out};
    exp = {3'b0, m_valid, m_done, (m_state != M_IDLE), m_idx, m_addr};
    check($sformatf("cycle e%0d {valid,done,busy,idx,addr}", edge_no), got, exp);
    if (valid === 1'b1) begin
      n_valid++;
      last_valid_edge = edge_no;
      if (n_valid == 1) first_idx = int'(idx_out);
      if (capture_on) cap[frame_s][idx_out] = addr_out;
    end
    if (done === 1'b1) done_edge = edge_no;
  endtask

  // Plain frame with en held high; S is scrambled while busy to show it is ignored.
  task automatic frame(input logic [2:0] s);
    begin_frame();
    frame_s = s;
    capture_on = 1'b1;
    step(0, 1, s, 1);
    for (int i = 1; i <= 34; i++) step(0, 0, s ^ 3'b111, 1);
    capture_on = 1'b0;
    check($sformatf("frame s=%0d valid count", s), 16'(n_valid), 16'd32);
    check($sformatf("frame s=%0d first idx", s), 16'(first_idx), 16'd0);
    check($sformatf("frame s=%0d last valid edge", s), 16'(last_valid_edge), 16'd32);
    check($sformatf("frame s=%0d done edge", s), 16'(done_edge), 16'd33);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0] s;
    logic [4:0] idx;
    logic [4:0] addr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{3'd0, 5'd1,  5'd16};
    vecs[1]  = '{3'd0, 5'd2,  5'd1};
    vecs[2]  = '{3'd0, 5'd31, 5'd31};
    vecs[3]  = '{3'd1, 5'd3,  5'd24};
    vecs[4]  = '{3'd1, 5'd4,  5'd1};
    vecs[5]  = '{3'd7, 5'd1,  5'd2};
    vecs[6]  = '{3'd7, 5'd16, 5'd1};
    vecs[7]  = '{3'd2, 5'd1,  5'd4};
    vecs[8]  = '{3'd2, 5'd5,  5'd20};
    vecs[9]  = '{3'd3, 5'd1,  5'd2};
    vecs[10] = '{3'd6, 5'd3,  5'd6};

    clr = 1; start = 1; S = 3'd5; en = 1;
    begin_frame();

    // Reset overrides start and en.
    step(1, 1, 3'd5, 1);
    step(1, 1, 3'd5, 1);
    check("reset outputs", {3'b0, valid, done, busy, idx_out, addr_out}, 16'd0);
    step(0, 0, 3'd0, 0);

    // One full frame per stage code.
    for (int s = 0; s < 8; s++) frame(3'(s));

    // Hand-computed address table.
    foreach (vecs[i]) begin
      check($sformatf("table s=%0d idx=%0d", vecs[i].s, vecs[i].idx),
            16'(cap[vecs[i].s][vecs[i].idx]), 16'(vecs[i].addr));
    end

    // Left-rotating each issued address by the stage amount recovers the index.
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < 32; i++) begin
        check($sformatf("rotl inverse s=%0d idx=%0d", s, i),
              16'(rotl5(cap[s][i], kf(3'(s)))), 16'(i));
      end
    end

    // en pattern 1,0,0,1: two stall cycles stretch the frame by two edges.
    begin_frame();
    step(0, 1, 3'd2, 1);
    for (int i = 1; i <= 40; i++) step(0, 0, 3'd2, (i == 2 || i == 3) ? 1'b0 : 1'b1);
    check("stall valid count", 16'(n_valid), 16'd32);
    check("stall done edge", 16'(done_edge), 16'd35);

    // start pulse with a new S at idx 10 of a running frame is ignored.
    begin_frame();
    step(0, 1, 3'd0, 1);
    for (int i = 1; i <= 40; i++) step(0, (i == 11), (i == 11) ? 3'd6 : 3'd0, 1);
    check("busy start valid count", 16'(n_valid), 16'd32);
    check("busy start done edge", 16'(done_edge), 16'd33);

    // clr right after idx 20 aborts the frame with no done pulse.
    begin_frame();
    step(0, 1, 3'd1, 1);
    for (int i = 1; i <= 21; i++) step(0, 0, 3'd1, 1);
    check("pre-abort idx", 16'(idx_out), 16'd20);
    step(1, 0, 3'd1, 1);
    check("abort outputs", {3'b0, valid, done, busy, idx_out, addr_out}, 16'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 3'd1, 1);
    check("abort no done", 16'(done_edge), 16'hFFFF);
    frame(3'd3);

    // start held high through the done cycle launches the next frame at once.
    begin_frame();
    step(0, 1, 3'd4, 1);
    for (int i = 1; i <= 70; i++) step(0, 1, 3'd4, 1);
    check("back-to-back second done edge", 16'(done_edge), 16'd67);
    step(1, 0, 3'd0, 0);
    step(0, 0, 3'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
